// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch controller states
//   fetch_entry_t    : one decoded-side buffer entry {inst, pc, pc_plus_4}
//   word_align()     : clears the byte-offset bits of an address
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
//   imem_req_*  : fetch request channel (valid/ready, word address)
//   imem_resp_* : in-order response channel (valid, data)
//   inst_*      : decode-side channel (valid/ready, {inst, pc, pc+4})
// modport master : the fetch unit
// modport slave  : memory + decode environment
interface if_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus_4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst_data, inst_pc, inst_pc_plus_4,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst_data, inst_pc, inst_pc_plus_4,
    output inst_ready
  );
endinterface

// File: rtl/if_fetch_buf.sv
// fetch_buf: BUF_DEPTH-entry FIFO of fetch entries.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   count      : number of valid entries
//   head       : oldest entry (undefined contents when count == 0)
module fetch_buf
  import mips_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(BUF_DEPTH):0] count,
  output fetch_entry_t               head
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [BUF_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           push_ok;
  logic           pop_ok;

  always_comb begin
    push_ok = push && (count < CW'(BUF_DEPTH));
    pop_ok  = pop && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: the top masks the head while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end. Owns the PC, issues one word fetch
// at a time over imem_req_*, buffers responses and hands {inst, pc, pc+4}
// to decode. A redirect restarts the stream and discards stale fetches.
//   clk, rst       : clock, asynchronous active-high reset
//   redirect_valid : one-cycle pulse, restart fetching at redirect_addr
//   redirect_addr  : new PC, low two bits ignored
//   bus            : memory request/response and decode channels (master)
module if_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  if_fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   req_pc;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          req_fire;
  logic          resp;
  logic          push;
  logic          pop;
  logic          slot_free_next;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  fetch_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (cnt),
    .head       (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (req_fire) req_pc <= pc;
    end
  end

  always_comb begin
    req_fire   = (state == REQ) && bus.imem_req_ready;
    resp       = bus.imem_resp_valid && ((state == WAIT) || (state == DROP));
    pop        = (cnt != '0) && bus.inst_ready;
    push       = (state == WAIT) && resp && !redirect_valid;
    push_entry = '{inst: bus.imem_resp_data, pc: req_pc, pc_plus_4: req_pc + 32'd4};

    // Occupancy after this cycle; the outstanding fetch is not yet counted,
    // so "< depth" means a slot can be reserved for the next request.
    cnt_next       = redirect_valid ? '0 : (cnt + CW'(push) - CW'(pop));
    slot_free_next = cnt_next < DEPTH_C;

    pc_next = pc;
    if (redirect_valid) pc_next = word_align(redirect_addr);
    else if (req_fire)  pc_next = pc + 32'd4;

    state_next = state;
    unique case (state)
      IDLE: begin
        if (redirect_valid || slot_free_next) state_next = REQ;
      end
      REQ: begin
        if (req_fire) state_next = redirect_valid ? DROP : WAIT;
        else          state_next = REQ;
      end
      WAIT: begin
        if (resp) begin
          if (redirect_valid || slot_free_next) state_next = REQ;
          else                                  state_next = IDLE;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        // The stale response retires the only outstanding fetch, so leave
        // even if another redirect lands in the same cycle; nothing else
        // would ever arrive to release DROP.
        if (resp) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = (state == REQ) ? pc : '0;

  assign bus.inst_valid     = (cnt != '0);
  assign bus.inst_data      = (cnt != '0) ? head.inst      : '0;
  assign bus.inst_pc        = (cnt != '0) ? head.pc        : '0;
  assign bus.inst_pc_plus_4 = (cnt != '0) ? head.pc_plus_4 : '0;

endmodule
